// File: rtl/ysyx_22040759_mem_arbiter_pkg.sv
// Shared types and defaults for the IFU/LSU memory arbiter.
// Holds the state and owner encodings and the default bus widths and starvation limit.
package ysyx_22040759_mem_arbiter_pkg;

  localparam int ADDR_W_DEF     = 64;
  localparam int DATA_W_DEF     = 64;
  localparam int STARVE_MAX_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_IFU = 1'b0,
    OWNER_LSU = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/ysyx_22040759_arb_starve_cnt.sv
// Saturating count of LSU grants taken while the IFU was waiting.
// force_ifu rises once the count reaches STARVE_MAX, handing the next grant to the IFU.
module ysyx_22040759_arb_starve_cnt
  import ysyx_22040759_mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic lsu_grant,
  input  logic ifu_grant,
  input  logic ifu_waiting,
  output logic force_ifu
);

  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (ifu_grant) begin
      cnt_d = '0;
    end else if (lsu_grant && ifu_waiting && (cnt_q < CW'(STARVE_MAX))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_ifu = (cnt_q >= CW'(STARVE_MAX));

endmodule

// File: rtl/ysyx_22040759_mem_arbiter.sv
// Shares one non-pipelined memory port between instruction fetch and load/store.
// LSU wins by default; the starvation counter forces an IFU grant after a run of LSU wins.
module ysyx_22040759_mem_arbiter
  import ysyx_22040759_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int STARVE_MAX     = STARVE_MAX_DEF,
  parameter bit CHECK_SPURIOUS = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_req_addr,
  output logic                ifu_resp_valid,
  output logic [DATA_W-1:0]   ifu_resp_data,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_req_addr,
  input  logic                lsu_req_wen,
  input  logic [DATA_W-1:0]   lsu_req_wdata,
  input  logic [DATA_W/8-1:0] lsu_req_wmask,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   lsu_resp_data,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_wen,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_data,
  output logic                busy
);

  localparam int MASK_W = DATA_W / 8;

  arb_state_e        state_q, state_d;
  arb_owner_e        owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MASK_W-1:0] wmask_q, wmask_d;

  logic force_ifu;
  logic grant_lsu;
  logic grant_ifu;

  // Readies are held low during reset so nothing is accepted while the port is being cleared.
  always_comb begin
    grant_lsu = 1'b0;
    grant_ifu = 1'b0;
    if (!rst && (state_q == ST_IDLE)) begin
      if (lsu_req_valid && (!ifu_req_valid || !force_ifu)) begin
        grant_lsu = 1'b1;
      end else if (ifu_req_valid) begin
        grant_ifu = 1'b1;
      end
    end
  end

  assign ifu_req_ready = grant_ifu;
  assign lsu_req_ready = grant_lsu;

  ysyx_22040759_arb_starve_cnt #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_cnt (
    .clk         (clk),
    .rst         (rst),
    .lsu_grant   (grant_lsu),
    .ifu_grant   (grant_ifu),
    .ifu_waiting (ifu_req_valid),
    .force_ifu   (force_ifu)
  );

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    addr_d         = addr_q;
    wen_d          = wen_q;
    wdata_d        = wdata_q;
    wmask_d        = wmask_q;
    mem_req_valid  = 1'b0;
    ifu_resp_valid = 1'b0;
    ifu_resp_data  = '0;
    lsu_resp_valid = 1'b0;
    lsu_resp_data  = '0;
    case (state_q)
      ST_IDLE: begin
        if (grant_lsu) begin
          owner_d = OWNER_LSU;
          addr_d  = lsu_req_addr;
          wen_d   = lsu_req_wen;
          wdata_d = lsu_req_wdata;
          wmask_d = lsu_req_wmask;
          state_d = ST_REQ;
        end else if (grant_ifu) begin
          owner_d = OWNER_IFU;
          addr_d  = ifu_req_addr;
          wen_d   = 1'b0;
          wdata_d = '0;
          wmask_d = '0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        // A response is only honoured here; a store is acknowledged with zero data.
        if (mem_resp_valid) begin
          state_d = ST_IDLE;
          if (owner_q == OWNER_LSU) begin
            lsu_resp_valid = 1'b1;
            lsu_resp_data  = wen_q ? '0 : mem_resp_data;
          end else begin
            ifu_resp_valid = 1'b1;
            ifu_resp_data  = mem_resp_data;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWNER_IFU;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
    end
  end

  assign mem_req_addr  = addr_q;
  assign mem_req_wen   = wen_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_wmask = wmask_q;
  assign busy          = (state_q != ST_IDLE);

  // A downstream response with nothing outstanding points at a protocol bug in the memory side.
  generate
    if (CHECK_SPURIOUS) begin : g_spurious_check
      spurious_resp_a : assert property (
        @(posedge clk) disable iff (rst) !(mem_resp_valid && (state_q != ST_RESP))
      ) else $error("mem_resp_valid received with no outstanding transaction");
    end
  endgenerate

endmodule
